// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and parity selectors for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with registered full/empty/level
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;
    logic [AW:0]      level_n;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign level_n = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level_n;
            full   <= level_n == (AW+1)'(DEPTH);
            empty  <= level_n == '0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with single-clock baud tick
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          uart_tx
);

    localparam int CW = $clog2(CLK_DIV);

    state_t               state, state_n;
    logic [CW-1:0]        cnt;
    logic                 tick;
    logic [DATA_BITS-1:0] shift, shift_n, rd_data;
    logic [3:0]           idx, idx_n;
    logic                 par, par_n, load, tx_n;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (load),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign tick = state != IDLE && cnt == CW'(CLK_DIV - 1);
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        par_n   = par;
        load    = 1'b0;
        case (state)
            IDLE:  load = !empty;
            START: state_n = tick ? DATA : START;
            DATA:
                if (tick) begin
                    shift_n = shift >> 1;
                    idx_n   = idx == 4'(DATA_BITS - 1) ? 4'd0 : idx + 4'd1;
                    state_n = idx != 4'(DATA_BITS - 1) ? DATA : PARITY != PAR_NONE ? PAR : STOP;
                end
            PAR:   state_n = tick ? STOP : PAR;
            STOP:
                if (tick) begin
                    load    = idx == 4'(STOP_BITS - 1) && !empty;
                    idx_n   = idx + 4'd1;
                    state_n = idx == 4'(STOP_BITS - 1) ? IDLE : STOP;
                end
            default: state_n = IDLE;
        endcase
        if (load) begin
            shift_n = rd_data;
            idx_n   = 4'd0;
            par_n   = ^rd_data ^ (PARITY == PAR_ODD);
            state_n = START;
        end
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PAR ? par_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            idx      <= '0;
            par      <= 1'b0;
            uart_tx  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            shift    <= shift_n;
            idx      <= idx_n;
            par      <= par_n;
            uart_tx  <= tx_n;
            overflow <= overflow || (wr_en && full);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO flags, overflow and reset
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic [3:0] rst, we;
    logic [7:0] wd0, wd1, wd2;
    logic [6:0] wd3;
    logic       full [4], empty [4], ovf [4], busy [4], tx [4];
    logic [2:0] lvl [4];
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
        .clk(clk), .reset(rst[0]), .wr_data(wd0), .wr_en(we[0]), .full(full[0]), .empty(empty[0]),
        .level(lvl[0]), .overflow(ovf[0]), .busy(busy[0]), .uart_tx(tx[0]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
        .clk(clk), .reset(rst[1]), .wr_data(wd1), .wr_en(we[1]), .full(full[1]), .empty(empty[1]),
        .level(lvl[1]), .overflow(ovf[1]), .busy(busy[1]), .uart_tx(tx[1]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
        .clk(clk), .reset(rst[2]), .wr_data(wd2), .wr_en(we[2]), .full(full[2]), .empty(empty[2]),
        .level(lvl[2]), .overflow(ovf[2]), .busy(busy[2]), .uart_tx(tx[2]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) d3 (
        .clk(clk), .reset(rst[3]), .wr_data(wd3), .wr_en(we[3]), .full(full[3]), .empty(empty[3]),
        .level(lvl[3]), .overflow(ovf[3]), .busy(busy[3]), .uart_tx(tx[3]));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int k, input logic [7:0] d);
        case (k)
            0: wd0 = d;
            1: wd1 = d;
            2: wd2 = d;
            default: wd3 = d[6:0];
        endcase
        we[k] = 1'b1;
        step;
        we[k] = 1'b0;
    endtask

    // bits[i] is the i-th bit on the line (start first); each bit must hold for 4 cycles
    task automatic chk_frame(input int k, input logic [15:0] bits, input int n, input bit chk_empty, input string tag);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < 4; c++) begin
                chk1($sformatf("%s_tx_b%0d_c%0d", tag, i, c), tx[k], bits[i]);
                if (c == 0)
                    chk1($sformatf("%s_busy_b%0d", tag, i), busy[k], 1'b1);
                if (chk_empty)
                    chk1($sformatf("%s_empty_b%0d_c%0d", tag, i, c), empty[k], 1'b1);
                step;
            end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk1({tag, "_idle_tx"}, tx[k], 1'b1);
        chk1({tag, "_idle_busy"}, busy[k], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 4'hF;
        we  = 4'h0;
        wd0 = '0;
        wd1 = '0;
        wd2 = '0;
        wd3 = '0;
        step;
        step;
        rst = 4'h0;
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("rst_tx%0d", k), tx[k], 1'b1);
            chk1($sformatf("rst_busy%0d", k), busy[k], 1'b0);
            chk1($sformatf("rst_full%0d", k), full[k], 1'b0);
            chk1($sformatf("rst_empty%0d", k), empty[k], 1'b1);
            chk3($sformatf("rst_level%0d", k), lvl[k], 3'd0);
            chk1($sformatf("rst_ovf%0d", k), ovf[k], 1'b0);
        end

        wr(0, 8'h55);
        chk1("w55_empty", empty[0], 1'b0);
        chk3("w55_level", lvl[0], 3'd1);
        chk1("w55_tx_before_pop", tx[0], 1'b1);
        step;
        chk_frame(0, 16'h02AA, 10, 1'b1, "f55");
        chk_idle(0, "f55");

        wr(1, 8'h07);
        step;
        chk_frame(1, 16'h060E, 11, 1'b0, "even07");
        chk_idle(1, "even07");
        wr(2, 8'h07);
        step;
        chk_frame(2, 16'h040E, 11, 1'b0, "odd07");
        chk_idle(2, "odd07");
        wr(3, 8'h7F);
        step;
        chk_frame(3, 16'h06FE, 11, 1'b0, "7o2");
        chk_idle(3, "7o2");

        wr(0, 8'h41);
        chk3("b2b_level_a", lvl[0], 3'd1);
        wr(0, 8'h42);
        chk3("b2b_level_b", lvl[0], 3'd1);
        chk_frame(0, 16'h0282, 10, 1'b0, "b2b41");
        chk3("b2b_level_c", lvl[0], 3'd0);
        chk_frame(0, 16'h0284, 10, 1'b0, "b2b42");
        chk_idle(0, "b2b");

        wr(0, 8'h00);
        step;
        wr(0, 8'h11);
        chk3("ovf_level1", lvl[0], 3'd1);
        wr(0, 8'h22);
        chk3("ovf_level2", lvl[0], 3'd2);
        wr(0, 8'h33);
        chk3("ovf_level3", lvl[0], 3'd3);
        chk1("ovf_notfull3", full[0], 1'b0);
        wr(0, 8'h44);
        chk3("ovf_level4", lvl[0], 3'd4);
        chk1("ovf_full4", full[0], 1'b1);
        chk1("ovf_clear4", ovf[0], 1'b0);
        wr(0, 8'h55);
        chk3("ovf_level5", lvl[0], 3'd4);
        chk1("ovf_full5", full[0], 1'b1);
        chk1("ovf_set5", ovf[0], 1'b1);
        repeat (35) step;
        chk3("ovf_level_pop", lvl[0], 3'd3);
        chk1("ovf_full_pop", full[0], 1'b0);
        chk_frame(0, 16'h0222, 10, 1'b0, "ovf11");
        chk_frame(0, 16'h0244, 10, 1'b0, "ovf22");
        chk_frame(0, 16'h0266, 10, 1'b0, "ovf33");
        chk_frame(0, 16'h0288, 10, 1'b0, "ovf44");
        chk_idle(0, "ovf");
        chk1("ovf_empty_end", empty[0], 1'b1);
        chk1("ovf_sticky", ovf[0], 1'b1);
        for (int i = 0; i < 8; i++) begin
            step;
            chk1($sformatf("ovf_no5th_%0d", i), tx[0], 1'b1);
        end

        wr(0, 8'hA5);
        step;
        repeat (17) step;
        chk1("mid_bit3", tx[0], 1'b0);
        wr(0, 8'hFF);
        chk3("mid_level", lvl[0], 3'd1);
        rst[0] = 1'b1;
        step;
        rst[0] = 1'b0;
        chk1("mid_rst_tx", tx[0], 1'b1);
        chk3("mid_rst_level", lvl[0], 3'd0);
        chk1("mid_rst_busy", busy[0], 1'b0);
        chk1("mid_rst_ovf", ovf[0], 1'b0);
        chk1("mid_rst_empty", empty[0], 1'b1);
        step;
        chk1("mid_stay_idle", tx[0], 1'b1);
        wr(0, 8'h3C);
        step;
        chk_frame(0, 16'h0278, 10, 1'b0, "f3c");
        chk_idle(0, "f3c");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
